// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory controller sitting behind the CPU memory port.
// Accepts one read or write per strobe/ready handshake, inserts WAIT_STATES
// idle cycles, then answers with a one-cycle oMemReady pulse. Serves a
// word-addressed RAM, a read-only free-running cycle counter and a GPIO
// output register. A side-band load port preloads the RAM.
//
// Optional build macro: MEM_CTRL_ALIGN_CHECK_EN adds oMemFault and turns
// misaligned requests into faulting no-ops.
//
// Ports:
//   iClk, iRst             clock, asynchronous active-high reset
//   iMemAddr, iMemData     CPU byte address and write data
//   iMemRead, iMemWrite    request strobes (both high = write)
//   oMemData, oMemReady    read data (zero unless ready), completion pulse
//   iLoadEn/Addr/Data      RAM preload port, wins over a same-edge CPU write
//   oMemFault              misaligned-access flag (MEM_CTRL_ALIGN_CHECK_EN)
//   oGpio                  GPIO register value
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] CNT_ADDR    = 32'hFFFF_FFF0,
    parameter logic [31:0] GPIO_ADDR   = 32'hFFFF_FFF4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [31:0]           iMemAddr,
    input  logic [31:0]           iMemData,
    output logic [31:0]           oMemData,
    input  logic                  iMemRead,
    input  logic                  iMemWrite,
    output logic                  oMemReady,
    input  logic                  iLoadEn,
    input  logic [ADDR_WIDTH-1:0] iLoadAddr,
    input  logic [31:0]           iLoadData,
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    output logic                  oMemFault,
`endif
    output logic [31:0]           oGpio
);

    localparam int unsigned DW        = 32;
    localparam int unsigned WCW       = 4;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    write_q;
    logic [DW-1:0]           addr_q, wdata_q, cnt_cap_q, cnt_q, gpio_q, rdata_q;
    logic [WCW-1:0]          wait_cnt_q;
    logic                    ready_q;
    logic [DW-1:0]           mem [DEPTH];

    logic                    req, accept, enter_resp;
    logic                    cur_write;
    logic [DW-1:0]           cur_addr, cur_wdata, cur_cnt, addr_word, rd_val;
    logic                    hit_cnt, hit_gpio, hit_ram, misaligned;
    logic                    ram_we, gpio_we;
    logic [ADDR_WIDTH-1:0]   ram_idx;

    assign req        = iMemRead | iMemWrite;
    assign accept     = (state_q == S_IDLE) && req;
    assign enter_resp = (state_d == S_RESP);

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_cnt_q == '0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access commits on the acceptance edge itself,
    // so the live inputs are used while idle and the latched copy afterwards.
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_cnt   = cnt_cap_q;
        if (state_q == S_IDLE) begin
            cur_write = iMemWrite;
            cur_addr  = iMemAddr;
            cur_wdata = iMemData;
            cur_cnt   = cnt_q;
        end
    end

    // Address decode: counter, then GPIO, then RAM; low two bits ignored
    assign addr_word = cur_addr & ~32'd3;
    assign hit_cnt   = (addr_word == CNT_ADDR);
    assign hit_gpio  = !hit_cnt && (addr_word == GPIO_ADDR);
    assign hit_ram   = !hit_cnt && !hit_gpio && (cur_addr[DW-1:ADDR_WIDTH+2] == '0);
    assign ram_idx   = cur_addr[ADDR_WIDTH+1:2];

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    assign misaligned = (cur_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign ram_we  = enter_resp && !iRst && cur_write && hit_ram && !misaligned;
    assign gpio_we = enter_resp && cur_write && hit_gpio && !misaligned;

    // Read mux; unmapped, misaligned and write accesses return zero
    always_comb begin
        rd_val = '0;
        if (!misaligned && !cur_write) begin
            if (hit_cnt)       rd_val = cur_cnt;
            else if (hit_gpio) rd_val = gpio_q;
            else if (hit_ram)  rd_val = mem[ram_idx];
        end
    end

    // Request latch, wait counter, cycle counter, GPIO and response registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_cap_q  <= '0;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
            gpio_q     <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (accept) begin
                write_q    <= iMemWrite;
                addr_q     <= iMemAddr;
                wdata_q    <= iMemData;
                cnt_cap_q  <= cnt_q;
                wait_cnt_q <= WCW'(WAIT_LOAD);
            end else if ((state_q == S_WAIT) && (wait_cnt_q != '0)) begin
                wait_cnt_q <= wait_cnt_q - WCW'(1);
            end
            ready_q <= enter_resp;
            rdata_q <= enter_resp ? rd_val : '0;
            if (gpio_we) gpio_q <= cur_wdata;
        end
    end

    // RAM array (not reset); the load port is written last so it wins a clash
    always_ff @(posedge iClk) begin
        if (ram_we)  mem[ram_idx]   <= cur_wdata;
        if (iLoadEn) mem[iLoadAddr] <= iLoadData;
    end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    logic fault_q;

    // Fault flag pulses alongside ready for misaligned requests
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= enter_resp && misaligned;
        end
    end

    assign oMemFault = fault_q;
`endif

    assign oMemReady = ready_q;
    assign oMemData  = rdata_q;
    assign oGpio     = gpio_q;

endmodule
